// File: rtl/tick_period_monitor_pkg.sv
// rtl/tick_period_monitor_pkg.sv - shared states, default period and match window for tick checkers
package tick_period_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } mon_state_t;

    // Same terminal count the timebase uses (0..500 inclusive).
    localparam int unsigned DEFAULT_EXPECTED_PERIOD = 501;

    // Written without subtraction so a tolerance larger than the period cannot wrap.
    function automatic logic in_window(input int unsigned count,
                                       input int unsigned expected,
                                       input int unsigned tol);
        return ((count + tol) >= expected) && (count <= (expected + tol));
    endfunction

endpackage

// File: rtl/tick_interval_counter.sv
// rtl/tick_interval_counter.sv - load-on-tick saturating interval counter with saturation flag
module tick_interval_counter #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    output logic [WIDTH-1:0] count,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX_COUNT = '1;
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    // The tick edge itself counts as clock 1 of the new interval; hold at all-ones.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= ONE;
        end else if (count != MAX_COUNT) begin
            count <= count + ONE;
        end
    end

    assign sat = (count == MAX_COUNT);

endmodule

// File: rtl/tick_period_monitor.sv
// rtl/tick_period_monitor.sv - tick period checker with lock/error/timeout; option TICK_MON_ERRCNT_EN
import tick_period_monitor_pkg::*;

module tick_period_monitor #(
    parameter int unsigned WIDTH           = 9,
    parameter int unsigned EXPECTED_PERIOD = DEFAULT_EXPECTED_PERIOD,
    parameter int unsigned TOLERANCE       = 0,
    parameter int unsigned LOCK_COUNT      = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             tick_in,
    output logic [WIDTH-1:0] period_out,
    output logic             period_valid_out,
    output logic             locked_out,
    output logic             error_out,
    output logic             timeout_out
`ifdef TICK_MON_ERRCNT_EN
    ,
    output logic [7:0]       error_count_out
`endif
);

    if (EXPECTED_PERIOD + TOLERANCE >= (2 ** WIDTH) - 1) begin : g_bad_width
        $error("EXPECTED_PERIOD+TOLERANCE must be below the counter saturation value");
    end
    if (LOCK_COUNT < 1 || LOCK_COUNT > 15) begin : g_bad_lock_count
        $error("LOCK_COUNT must be within 1..15");
    end

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

    mon_state_t       state, state_next;
    logic [3:0]       match_cnt, match_next;
    logic [WIDTH-1:0] cnt;
    logic             sat;
    logic             match;
    logic [WIDTH-1:0] period_next;
    logic             valid_next, error_next, timeout_next;

    tick_interval_counter #(.WIDTH(WIDTH)) u_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (tick_in),
        .count   (cnt),
        .sat     (sat)
    );

    assign match = in_window(32'(cnt), EXPECTED_PERIOD, TOLERANCE);

    // Next state and next output values; a tick always takes precedence over saturation.
    always_comb begin
        state_next   = state;
        match_next   = match_cnt;
        period_next  = period_out;
        valid_next   = 1'b0;
        error_next   = 1'b0;
        timeout_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tick_in) begin
                    state_next = ST_ACQUIRE;
                    match_next = '0;
                end
            end
            ST_ACQUIRE: begin
                if (tick_in) begin
                    period_next = cnt;
                    valid_next  = 1'b1;
                    if (match) begin
                        match_next = match_cnt + 4'd1;
                        if (match_cnt + 4'd1 == LOCK_TARGET) begin
                            state_next = ST_LOCKED;
                        end
                    end else begin
                        match_next = '0;
                    end
                end else if (sat) begin
                    timeout_next = 1'b1;
                    match_next   = '0;
                    state_next   = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (tick_in) begin
                    period_next = cnt;
                    valid_next  = 1'b1;
                    if (!match) begin
                        error_next = 1'b1;
                        match_next = '0;
                        state_next = ST_ACQUIRE;
                    end
                end else if (sat) begin
                    timeout_next = 1'b1;
                    error_next   = 1'b1;
                    match_next   = '0;
                    state_next   = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                match_next = '0;
            end
        endcase
    end

    // State, match counter and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            match_cnt        <= '0;
            period_out       <= '0;
            period_valid_out <= 1'b0;
            locked_out       <= 1'b0;
            error_out        <= 1'b0;
            timeout_out      <= 1'b0;
        end else begin
            state            <= state_next;
            match_cnt        <= match_next;
            period_out       <= period_next;
            period_valid_out <= valid_next;
            locked_out       <= (state_next == ST_LOCKED);
            error_out        <= error_next;
            timeout_out      <= timeout_next;
        end
    end

`ifdef TICK_MON_ERRCNT_EN
    // Saturating error tally, moving in the same cycle error_out pulses.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            error_count_out <= '0;
        end else if (error_next && error_count_out != 8'hFF) begin
            error_count_out <= error_count_out + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tick_period_monitor.sv
// tb/tb_tick_period_monitor.sv - directed self-checking bench for tick_period_monitor
module tb_tick_period_monitor;

    logic       clk;
    logic [2:0] rstn;
    logic [2:0] tick;

    logic [8:0] m_period;
    logic       m_valid, m_locked, m_err, m_to;
    logic [8:0] t_period;
    logic       t_valid, t_locked, t_err, t_to;
    logic [4:0] s_period;
    logic       s_valid, s_locked, s_err, s_to;
`ifdef TICK_MON_ERRCNT_EN
    logic [7:0] m_ecnt, t_ecnt, s_ecnt;
`endif

    int vectors;
    int miscompares;

    tick_period_monitor u_main (
        .clock(clk), .reset_n(rstn[0]), .tick_in(tick[0]),
        .period_out(m_period), .period_valid_out(m_valid), .locked_out(m_locked),
        .error_out(m_err), .timeout_out(m_to)
`ifdef TICK_MON_ERRCNT_EN
        , .error_count_out(m_ecnt)
`endif
    );

    tick_period_monitor #(.TOLERANCE(2)) u_tol (
        .clock(clk), .reset_n(rstn[1]), .tick_in(tick[1]),
        .period_out(t_period), .period_valid_out(t_valid), .locked_out(t_locked),
        .error_out(t_err), .timeout_out(t_to)
`ifdef TICK_MON_ERRCNT_EN
        , .error_count_out(t_ecnt)
`endif
    );

    tick_period_monitor #(.WIDTH(5), .EXPECTED_PERIOD(6), .LOCK_COUNT(1)) u_small (
        .clock(clk), .reset_n(rstn[2]), .tick_in(tick[2]),
        .period_out(s_period), .period_valid_out(s_valid), .locked_out(s_locked),
        .error_out(s_err), .timeout_out(s_to)
`ifdef TICK_MON_ERRCNT_EN
        , .error_count_out(s_ecnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock; afterwards outputs reflect the edge just taken.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse(input int sel);
        tick[sel] = 1'b1;
        step();
        tick[sel] = 1'b0;
    endtask

    // Next tick lands P clocks after the previous one.
    task automatic interval(input int sel, input int p);
        gap(p - 1);
        pulse(sel);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn        = 3'b000;
        tick        = 3'b000;
        gap(2);
        check_vec("rst_period", m_period, 0);
        check_vec("rst_valid", m_valid, 0);
        check_vec("rst_locked", m_locked, 0);
        check_vec("rst_error", m_err, 0);
        check_vec("rst_timeout", m_to, 0);
        rstn = 3'b111;

        // Acquisition at nominal period.
        pulse(0);
        check_vec("first_tick_valid", m_valid, 0);
        for (int k = 1; k <= 4; k++) begin
            interval(0, 501);
            check_vec("acq_valid", m_valid, 1);
            check_vec("acq_period", m_period, 501);
            check_vec("acq_locked", m_locked, (k == 4) ? 1 : 0);
        end
        step();
        check_vec("valid_is_pulse", m_valid, 0);
        check_vec("lock_held", m_locked, 1);
        gap(-1 + 1);

        // Short interval while locked, then relock.
        interval(0, 499);
        check_vec("short_error", m_err, 1);
        check_vec("short_unlock", m_locked, 0);
        check_vec("short_period", m_period, 500);
        for (int k = 1; k <= 4; k++) begin
            interval(0, 501);
            check_vec("relock_error", m_err, 0);
            check_vec("relock_locked", m_locked, (k == 4) ? 1 : 0);
        end

        // Loss of tick while locked.
        gap(510);
        check_vec("pre_timeout", m_to, 0);
        step();
        check_vec("timeout_pulse", m_to, 1);
        check_vec("timeout_error", m_err, 1);
        check_vec("timeout_unlock", m_locked, 0);
        step();
        check_vec("timeout_once", m_to, 0);
        pulse(0);
        check_vec("idle_tick_valid", m_valid, 0);
        interval(0, 501);
        check_vec("post_to_valid", m_valid, 1);
        check_vec("post_to_locked", m_locked, 0);

        // Tick coincident with saturation: measured as 511, no timeout.
        interval(0, 511);
        check_vec("sat_tick_valid", m_valid, 1);
        check_vec("sat_tick_period", m_period, 511);
        check_vec("sat_tick_timeout", m_to, 0);

        // Reset mid-interval while locked, with a tick in the reset cycle.
        for (int k = 1; k <= 4; k++) interval(0, 501);
        check_vec("prereset_locked", m_locked, 1);
        gap(200);
        rstn[0] = 1'b0;
        tick[0] = 1'b1;
        step();
        rstn[0] = 1'b1;
        tick[0] = 1'b0;
        check_vec("midrst_period", m_period, 0);
        check_vec("midrst_locked", m_locked, 0);
        check_vec("midrst_valid", m_valid, 0);
        gap(500);
        pulse(0);
        check_vec("rst_tick_ignored", m_valid, 0);
        interval(0, 501);
        check_vec("after_rst_valid", m_valid, 1);
        check_vec("after_rst_locked", m_locked, 0);

        // Tolerance window of +-2.
        pulse(1);
        interval(1, 499);
        check_vec("tol499_error", t_err, 0);
        check_vec("tol499_period", t_period, 499);
        interval(1, 503);
        check_vec("tol503_period", t_period, 503);
        interval(1, 501);
        check_vec("tol501_locked", t_locked, 0);
        interval(1, 500);
        check_vec("tol500_locked", t_locked, 1);
        check_vec("tol500_error", t_err, 0);
        interval(1, 504);
        check_vec("tol504_error", t_err, 1);
        check_vec("tol504_locked", t_locked, 0);

        // Single-interval lock on the small instance, then forced mismatches.
        pulse(2);
        interval(2, 6);
        check_vec("small_lock", s_locked, 1);
        check_vec("small_period", s_period, 6);
        interval(2, 5);
        check_vec("small_error", s_err, 1);
        check_vec("small_unlock", s_locked, 0);
`ifdef TICK_MON_ERRCNT_EN
        check_vec("errcnt_first", s_ecnt, 1);
        for (int k = 0; k < 299; k++) begin
            interval(2, 6);
            interval(2, 5);
        end
        check_vec("errcnt_sat", s_ecnt, 255);
        check_vec("errcnt_last_err", s_err, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tick_period_monitor.md
Name: tick_period_monitor

Overview:
Receive-side counterpart of the free-running terminal-count timebase. Consumes a single-cycle tick pulse, measures the clock count between successive ticks and checks it against the expected period. Reports lock, per-interval measured period, mismatch errors and loss of tick (timeout). Sits downstream of the timebase in the HDMI TX timing path as a self-check and lock indicator.

Parameters:
WIDTH, 9, width of the interval counter and period_out; counter saturates at 2^WIDTH-1.
EXPECTED_PERIOD, 501, nominal clocks between tick pulses (timebase counts 0..500 inclusive).
TOLERANCE, 0, allowed absolute deviation, in clocks, from EXPECTED_PERIOD.
LOCK_COUNT, 4, consecutive matching intervals needed to assert lock; range 1..15.

Ports:
clock  input  1  system clock, rising edge.
reset_n  input  1  synchronous, active-low reset.
tick_in  input  1  single-cycle terminal-count pulse from the timebase.
period_out  output  WIDTH  last measured interval in clocks.
period_valid_out  output  1  one-cycle pulse when period_out updates.
locked_out  output  1  high while in LOCKED.
error_out  output  1  one-cycle pulse on mismatch or timeout while LOCKED.
timeout_out  output  1  one-cycle pulse when the interval counter saturates.

Behaviour:
- Single clock domain `clock`. Reset is synchronous, active-low (`reset_n`). Every register is updated only on the rising edge of `clock`.
- Reset: state=IDLE, cnt=0, match_cnt=0, period_out=0, all pulse outputs 0, locked_out=0. Reset mid-interval discards the partial measurement. A tick sampled in a reset cycle is ignored.
- Interval counter cnt: the edge that samples tick_in=1 loads cnt=1. Otherwise cnt increments by 1, saturating at 2^WIDTH-1. With ticks at cycles t0 and t0+501, cnt holds 501 at t0+501.
- Match: EXPECTED_PERIOD-TOLERANCE <= cnt <= EXPECTED_PERIOD+TOLERANCE, evaluated on cnt at the tick cycle.
- States and transitions:
  - IDLE: no reference tick yet. On tick: load cnt=1, go ACQUIRE, no period update.
  - ACQUIRE: on tick, period_out<=cnt and period_valid_out pulses. If match, match_cnt++; when match_cnt reaches LOCK_COUNT, go LOCKED. If mismatch, match_cnt<=0 and stay in ACQUIRE; the new interval starts at this tick.
  - LOCKED: on tick, update period as in ACQUIRE. If mismatch, pulse error_out, match_cnt<=0, go ACQUIRE.
- Timeout: when cnt reaches saturation (2^WIDTH-1) with no tick, pulse timeout_out once and go IDLE; if the state was LOCKED, error_out also pulses. cnt stays saturated until the next tick.
- Simultaneous tick and saturation: the tick wins. The interval is measured as 2^WIDTH-1 (a mismatch); no timeout pulse.
- Latency: all outputs are registered and change one clock after the tick cycle. locked_out rises one clock after the LOCK_COUNT-th matching tick and falls one clock after the failing tick or timeout.
- Width rule: EXPECTED_PERIOD+TOLERANCE must be < 2^WIDTH-1; violating this is an elaboration error (static check).

Optional Feature:
TICK_MON_ERRCNT_EN: when defined, adds output error_count_out [7:0]. It increments on each error_out pulse, saturates at 255 and is cleared only by reset. When not defined, the port and logic are absent and all other behaviour is identical.

Decomposition:
- Shared include/package: state encodings IDLE/ACQUIRE/LOCKED, the default EXPECTED_PERIOD=501 shared with the timebase terminal count, and the match-window function.
- One natural sub-module: tick_interval_counter (load-on-tick, saturating counter, sat flag), reusable by other timing checkers.

Test Plan:
- Ticks every 501 clocks after reset release -> period_valid_out on each tick except the first, period_out=501; locked_out rises one clock after the 5th tick (4th matching interval).
- When locked, one interval of 500 clocks -> error_out pulses once, locked_out falls, period_out=500; relocks after 4 further 501-clock intervals.
- When locked, tick stops -> timeout_out and error_out pulse together 511 clocks after the last tick; state returns to IDLE; the next tick gives no period_valid_out.
- TOLERANCE=2, intervals 499, 503, 501, 500 -> all match; lock after the 4th; no error_out.
- reset_n low for 1 cycle mid-interval while locked -> next cycle all outputs 0 and locked_out=0; a tick in the reset cycle is ignored.
- TICK_MON_ERRCNT_EN defined, 300 forced mismatches while locked -> error_count_out saturates at 255.
